led_share_arbiter: RTL
======================

# led_share_arbiter

Round-robin arbiter that shares the 8-bit board LED bank between four status sources. Each requester presents an 8-bit pattern. The arbiter grants one requester at a time and drives its pattern onto `led` for a fixed hold window, then blanks for a gap window before the next grant. It sits between the status-producing blocks (HDMI link, PLL lock, frame counters, debug) and the LED pins, and replaces direct per-block LED drive.

## Interface
- `HOLD_CYCLES`, default 32'h00800000: SHOW duration in enabled clock cycles; must be ≥1.
- `GAP_CYCLES`, default 32'h00100000: blank gap after each SHOW; must be ≥1.
- `BLINK_CYCLES`, default 32'h00200000: blink half-period; used only when `LED_ARB_BLINK_EN` is defined; must be ≥1.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: global advance enable; low freezes all state, timers and outputs.
- `req` in 4: request per source; level-sensitive, held high while the source wants display.
- `req_pattern` in 32: four patterns; source i occupies bits [8i+7:8i].
- `grant` out 4: one-hot; high for the whole SHOW of the granted source.
- `done` out 4: one-cycle pulse to source i when its SHOW completes normally.
- `busy` out 1: high in SHOW or GAP.
- `led` out 8: LED drive.

## Operation
- States: IDLE, SHOW, GAP. All are registered outputs.
- Reset values: state=IDLE, `grant`=0, `done`=0, `busy`=0, `led`=0, timer=0, last pointer=3 (source 0 has first priority).
- When `en`=0, nothing changes. This includes the timer, state, `led` and `grant`. The `done` output is forced to 0 on that edge and no pulse is lost; the pulse is deferred to the next enabled completion edge.
- IDLE, `en`=1, any `req` high:
  - Select the first requesting index scanning last+1, last+2, last+3, last (mod 4).
  - Latch that source's `req_pattern` byte.
  - Set `grant` one-hot, `led`=pattern, timer=0.
  - Go to SHOW and update the last pointer to the selected index.
- IDLE with no request: stay in IDLE, `led`=0.
- SHOW:
  - The timer increments each enabled cycle.
  - At timer==HOLD_CYCLES-1: pulse `done[i]`, clear `grant`, set `led`=0, timer=0, go to GAP.
  - The pattern is latched once at entry. Changes on `req_pattern` during SHOW are ignored.
- Abort: if `req[granted]` is sampled low during SHOW, go to GAP on that edge. In this case there is no `done` pulse, `grant` clears and `led`=0.
- GAP: `led`=0. At timer==GAP_CYCLES-1, go to IDLE. Arbitration happens on the next enabled IDLE cycle.
- A requester held high continuously is served again only after every other active requester has had a turn.
- Timer width is 32 bits, with compare by equality only. A parameter of 0 is illegal and its behaviour is undefined.

## Timing
- Grant latency: the request is sampled in IDLE, and `grant` and `led` are valid on the next edge (1 cycle).
- SHOW lasts exactly HOLD_CYCLES enabled cycles. GAP lasts exactly GAP_CYCLES enabled cycles. There is 1 IDLE cycle before each new grant.
- With all sources requesting continuously, the period per grant is HOLD_CYCLES+GAP_CYCLES+1 enabled cycles.
- The `done` pulse is coincident with the edge on which `grant` falls.
- Reset is synchronous and dominates `en`. Asserting it mid-SHOW returns the block to reset values on that edge, with no `done` pulse.

## Configuration
- `LED_ARB_BLINK_EN` defined:
  - During SHOW, `led` alternates between pattern and 0.
  - The ON phase starts at SHOW entry.
  - The phase toggles each time a BLINK_CYCLES counter expires; the counter is reset on SHOW entry.
- `LED_ARB_BLINK_EN` undefined: `led`=pattern steady throughout SHOW, and the blink counter is not built.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, GAP_CYCLES=2, BLINK_CYCLES=2.
- **Reset state.** Reset, then `req`=4'b0100 with pattern2=8'hA5. Expected: `grant`=4'b0100 one cycle later, `led`=A5 for 4 cycles, `done[2]` pulse, `led`=0 for 2 cycles, `busy` low after that.
- **Round-robin fairness.** `req`=4'b1111 held with patterns 11/22/33/44. Expected: grant order 0,1,2,3,0, each in a 7-cycle period; `led` sequence 11,22,33,44.
- **Abort.** Drop `req[1]` on the 2nd SHOW cycle. Expected: `grant` clears and `led`=0 next edge, no `done[1]`, GAP lasts 2 cycles.
- **Freeze.** Pulse `en`=0 for 5 cycles mid-SHOW and mid-GAP. Expected: windows extend by exactly 5 cycles, `led` and `grant` are held, a single `done` pulse still occurs.
- **Reset mid-SHOW and pattern latch.** Assert `rst_n`=0 at SHOW cycle 2. Expected: all outputs 0 next edge. Separately, change `req_pattern` during SHOW. Expected: `led` unchanged.
- **Blink.** With `LED_ARB_BLINK_EN` defined and HOLD_CYCLES=8, pattern 8'hFF. Expected `led` sequence: FF,FF,00,00,FF,FF,00,00. Without the macro: 8 cycles of FF.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// Requester/LED-side bundle for led_share_arbiter: request levels and patterns in,
// grant/done/busy status and the shared LED drive out.
interface led_share_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_pattern;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  led;

  modport master (
    output req,
    output req_pattern,
    input  grant,
    input  done,
    input  busy,
    input  led
  );

  modport slave (
    input  req,
    input  req_pattern,
    output grant,
    output done,
    output busy,
    output led
  );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 8-bit LED bank between four status sources (IDLE/SHOW/GAP).
// Optional SHOW-phase blinking is built only when LED_ARB_BLINK_EN is defined.
module led_share_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 32'h00800000,
  parameter int unsigned GAP_CYCLES   = 32'h00100000,
  parameter int unsigned BLINK_CYCLES = 32'h00200000
) (
  input logic                clk,
  input logic                rst_n,
  input logic                en,
  led_share_arbiter_if.slave bus
);

  localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GapLast  = 32'(GAP_CYCLES - 1);

  // Zero-length windows have no defined behaviour; refuse them at elaboration.
  if (HOLD_CYCLES == 0 || GAP_CYCLES == 0 || BLINK_CYCLES == 0) begin : g_param_check
    $error("led_share_arbiter: HOLD/GAP/BLINK_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [1:0]  last_q, last_d;

`ifdef LED_ARB_BLINK_EN
  localparam logic [31:0] BlinkLast = 32'(BLINK_CYCLES - 1);
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
`endif

  logic [1:0] sel;
  logic [1:0] cand;
  logic       any_req;

  // Scan last+4 down to last+1 so the nearest requester after last wins.
  always_comb begin
    sel     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (bus.req[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    led_d     = led_q;
    pattern_d = pattern_q;
    last_d    = last_q;
    done_d    = '0;
`ifdef LED_ARB_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
`endif

    if (en) begin
      unique case (state_q)
        StIdle: begin
          led_d = '0;
          if (any_req) begin
            state_d   = StShow;
            grant_d   = 4'b0001 << sel;
            pattern_d = bus.req_pattern[{sel, 3'b000} +: 8];
            led_d     = bus.req_pattern[{sel, 3'b000} +: 8];
            timer_d   = '0;
            last_d    = sel;
`ifdef LED_ARB_BLINK_EN
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
`endif
          end
        end

        StShow: begin
          if (!bus.req[last_q]) begin
            // Requester withdrew: skip straight to the gap, no completion pulse.
            state_d = StGap;
            grant_d = '0;
            led_d   = '0;
            timer_d = '0;
          end else if (timer_q == HoldLast) begin
            state_d = StGap;
            done_d  = grant_q;
            grant_d = '0;
            led_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
`ifdef LED_ARB_BLINK_EN
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
              led_d       = blink_on_q ? 8'h00 : pattern_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 32'd1;
            end
`endif
          end
        end

        StGap: begin
          led_d = '0;
          if (timer_q == GapLast) begin
            state_d = StIdle;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end

        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      led_q     <= '0;
      pattern_q <= '0;
      last_q    <= 2'd3;
`ifdef LED_ARB_BLINK_EN
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
      pattern_q <= pattern_d;
      last_q    <= last_d;
`ifdef LED_ARB_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.led   = led_q;

endmodule
